// File: rtl/hexfetch_pkg.sv
// hexfetch_pkg: shared types and constants for the hexagonal-search pixel fetch path
package hexfetch_pkg;
  localparam int NUM_POINTS = 7;
  localparam int NUM_SLOTS = 14;
  localparam int SLOT_W = 4;
  localparam int PT_W = 3;
  localparam int FRAME_DIM_DEF = 96;
  localparam int ADDR_W_DEF = 14;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;
endpackage

// File: rtl/hex_addr_gen.sv
// hex_addr_gen: maps a frame coordinate to a linear address and flags out-of-frame points
module hex_addr_gen
  import hexfetch_pkg::*;
#(
  parameter int COORD_W = 7,
  parameter int FRAME_DIM = FRAME_DIM_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic [ADDR_W-1:0]  addr,
  output logic               in_range
);
  assign in_range = int'(x) < FRAME_DIM && int'(y) < FRAME_DIM;
  assign addr = in_range ? ADDR_W'(y) * ADDR_W'(FRAME_DIM) + ADDR_W'(x) : '0;
endmodule

// File: rtl/hex_pixel_fetch_sequencer.sv
// hex_pixel_fetch_sequencer: serialises 14 hexagon-point reads onto one frame-memory port and gathers the pixels
module hex_pixel_fetch_sequencer
  import hexfetch_pkg::*;
#(
  parameter int COORD_W = 7,
  parameter int PIX_W = 8,
  parameter int FRAME_DIM = FRAME_DIM_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int MEM_LAT = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req,
  input  logic [NUM_POINTS*COORD_W-1:0] cur_x_flat,
  input  logic [NUM_POINTS*COORD_W-1:0] cur_y_flat,
  input  logic [NUM_POINTS*COORD_W-1:0] ref_x_flat,
  input  logic [NUM_POINTS*COORD_W-1:0] ref_y_flat,
  output logic                          busy,
  output logic                          done,
  output logic                          oob,
  output logic [NUM_POINTS*PIX_W-1:0]   cur_pix_flat,
  output logic [NUM_POINTS*PIX_W-1:0]   ref_pix_flat,
  output logic                          mem_rd_en,
  output logic                          mem_sel,
  output logic [ADDR_W-1:0]             mem_addr,
  input  logic [PIX_W-1:0]              mem_rd_data
);
  state_t state, state_nxt;
  logic [SLOT_W-1:0] slot;
  logic [NUM_POINTS*COORD_W-1:0] cx, cy, rx, ry;
  logic [PIX_W-1:0] pix [NUM_SLOTS];
  logic [MEM_LAT-1:0] tag_v;
  logic [SLOT_W-1:0] tag_s [MEM_LAT];
  logic [PT_W-1:0] pt;
  logic [COORD_W-1:0] px, py;
  logic [ADDR_W-1:0] addr;
  logic in_range, issue, accept, last_slot, drained;
  assign issue = state == S_ISSUE;
  assign accept = state == S_IDLE && req;
  assign last_slot = slot == SLOT_W'(NUM_SLOTS - 1);
  assign drained = slot == SLOT_W'(MEM_LAT - 1);
  assign mem_sel = issue && slot >= SLOT_W'(NUM_POINTS);
  assign pt = PT_W'(mem_sel ? slot - SLOT_W'(NUM_POINTS) : slot);
  assign px = mem_sel ? rx[pt*COORD_W +: COORD_W] : cx[pt*COORD_W +: COORD_W];
  assign py = mem_sel ? ry[pt*COORD_W +: COORD_W] : cy[pt*COORD_W +: COORD_W];
  hex_addr_gen #(.COORD_W(COORD_W), .FRAME_DIM(FRAME_DIM), .ADDR_W(ADDR_W)) u_addr (
    .x(px), .y(py), .addr(addr), .in_range(in_range)
  );
  assign mem_rd_en = issue && in_range;
  assign mem_addr = mem_rd_en ? addr : '0;
  assign busy = state != S_IDLE;
  assign done = state == S_DONE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    state_nxt = accept ? S_ISSUE :
                (issue && last_slot) ? S_DRAIN :
                (state == S_DRAIN && drained) ? S_DONE :
                done ? S_IDLE : state;
  end
  // slot doubles as the drain counter once all reads are issued
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      slot <= '0;
      oob <= 1'b0;
      {cx, cy, rx, ry} <= '0;
      tag_v <= '0;
      for (int i = 0; i < MEM_LAT; i++) tag_s[i] <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) pix[i] <= '0;
    end else begin
      slot <= ((issue && !last_slot) || state == S_DRAIN) ? slot + SLOT_W'(1) : '0;
      tag_v[0] <= mem_rd_en;
      tag_s[0] <= slot;
      for (int i = 1; i < MEM_LAT; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_s[i] <= tag_s[i-1];
      end
      if (tag_v[MEM_LAT-1]) pix[tag_s[MEM_LAT-1]] <= mem_rd_data;
      if (issue && !in_range) oob <= 1'b1;
      if (accept) begin
        {cx, cy, rx, ry} <= {cur_x_flat, cur_y_flat, ref_x_flat, ref_y_flat};
        oob <= 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) pix[i] <= '0;
      end
    end
  for (genvar p = 0; p < NUM_POINTS; p++) begin : g_flat
    assign cur_pix_flat[p*PIX_W +: PIX_W] = pix[p];
    assign ref_pix_flat[p*PIX_W +: PIX_W] = pix[p+NUM_POINTS];
  end
endmodule

// File: tb/tb_hex_pixel_fetch_sequencer.sv
// tb_hex_pixel_fetch_sequencer: scoreboard bench driving a MEM_LAT=1 and a MEM_LAT=3 instance
`define CHK(tag, got, exp) begin checks++; assert ((got) === (exp)) else begin failures++; $error("FAIL %s got=%0h exp=%0h", tag, got, exp); end end
module tb_hex_pixel_fetch_sequencer;
  localparam int CW = 7, PW = 8, AW = 14;
  typedef struct {logic sel; logic [AW-1:0] addr; int cyc;} rd_t;
  typedef struct {logic [7*PW-1:0] cur; logic [7*PW-1:0] rf; logic oob; int cyc;} res_t;
  logic clk = 0, rst_n = 0, req1 = 0, req3 = 0;
  logic [7*CW-1:0] cx, cy, rx, ry;
  logic busy1, done1, oob1, en1, sel1, busy3, done3, oob3, en3, sel3;
  logic [7*PW-1:0] cp1, rp1, cp3, rp3;
  logic [AW-1:0] a1, a3;
  logic [PW-1:0] d1, d3;
  logic [PW-1:0] d3p [3];
  rd_t rq1[$], rq3[$];
  res_t sq1[$], sq3[$];
  res_t last1, last3;
  int checks = 0, failures = 0, cyc = 0;
  int xs[7] = '{8, 10, 6, 9, 7, 9, 7};
  int ys[7] = '{8, 8, 8, 10, 10, 6, 6};
  always #5 clk = ~clk;

  hex_pixel_fetch_sequencer #(.MEM_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .cur_x_flat(cx), .cur_y_flat(cy),
    .ref_x_flat(rx), .ref_y_flat(ry), .busy(busy1), .done(done1), .oob(oob1),
    .cur_pix_flat(cp1), .ref_pix_flat(rp1), .mem_rd_en(en1), .mem_sel(sel1),
    .mem_addr(a1), .mem_rd_data(d1));
  hex_pixel_fetch_sequencer #(.MEM_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req(req3), .cur_x_flat(cx), .cur_y_flat(cy),
    .ref_x_flat(rx), .ref_y_flat(ry), .busy(busy3), .done(done3), .oob(oob3),
    .cur_pix_flat(cp3), .ref_pix_flat(rp3), .mem_rd_en(en3), .mem_sel(sel3),
    .mem_addr(a3), .mem_rd_data(d3));

  function automatic logic [PW-1:0] mdat(input logic s, input logic [AW-1:0] a);
    return s ? a[7:0] ^ 8'hA5 : a[7:0];
  endfunction
  always_ff @(posedge clk) d1 <= en1 ? mdat(sel1, a1) : 8'hEE;
  always_ff @(posedge clk) begin
    d3p[0] <= en3 ? mdat(sel3, a3) : 8'hEE;
    d3p[1] <= d3p[0];
    d3p[2] <= d3p[1];
  end
  assign d3 = d3p[2];

  task automatic mon(input int d, input logic en, sel, dn, ob, bz, input logic [AW-1:0] a,
                     input logic [7*PW-1:0] cp, rp);
    rd_t r;
    res_t s;
    int n;
    if (en) begin
      n = (d == 1) ? rq1.size() : rq3.size();
      `CHK("rd_expected", n > 0, 1'b1)
      if (n > 0) begin
        if (d == 1) r = rq1.pop_front();
        else r = rq3.pop_front();
        `CHK("rd_sel", sel, r.sel)
        `CHK("rd_addr", a, r.addr)
        `CHK("rd_cycle", cyc, r.cyc)
      end
    end else `CHK("addr_idle_zero", a, 14'd0)
    if (dn) begin
      n = (d == 1) ? sq1.size() : sq3.size();
      `CHK("done_expected", n > 0, 1'b1)
      if (n > 0) begin
        if (d == 1) s = sq1.pop_front();
        else s = sq3.pop_front();
        `CHK("done_cycle", cyc, s.cyc)
        `CHK("cur_pix", cp, s.cur)
        `CHK("ref_pix", rp, s.rf)
        `CHK("oob", ob, s.oob)
        `CHK("busy_at_done", bz, 1'b1)
        if (d == 1) last1 = s;
        else last3 = s;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    mon(1, en1, sel1, done1, oob1, busy1, a1, cp1, rp1);
    mon(3, en3, sel3, done3, oob3, busy3, a3, cp3, rp3);
  endtask

  task automatic expect_fetch(input int d);
    rd_t r;
    res_t s;
    logic [CW-1:0] x, y;
    logic in;
    logic [AW-1:0] a;
    logic [PW-1:0] v;
    int p;
    s.cur = '0; s.rf = '0; s.oob = 1'b0; s.cyc = cyc + 15 + d;
    for (int k = 0; k < 14; k++) begin
      p = k % 7;
      x = (k < 7) ? cx[p*CW +: CW] : rx[p*CW +: CW];
      y = (k < 7) ? cy[p*CW +: CW] : ry[p*CW +: CW];
      in = x < 7'd96 && y < 7'd96;
      a = 14'(y) * 14'd96 + 14'(x);
      v = in ? mdat(k >= 7, a) : 8'h00;
      if (k < 7) s.cur[p*PW +: PW] = v;
      else s.rf[p*PW +: PW] = v;
      if (!in) s.oob = 1'b1;
      if (in) begin
        r.sel = k >= 7; r.addr = a; r.cyc = cyc + 1 + k;
        if (d == 1) rq1.push_back(r);
        else rq3.push_back(r);
      end
    end
    if (d == 1) sq1.push_back(s);
    else sq3.push_back(s);
  endtask

  task automatic fire(input bit f1, input bit f3);
    if (f1) begin req1 = 1'b1; expect_fetch(1); end
    if (f3) begin req3 = 1'b1; expect_fetch(3); end
    tick();
    req1 = 1'b0;
    req3 = 1'b0;
  endtask

  task automatic set_pts(input int cdx, cdy, rdx, rdy);
    for (int p = 0; p < 7; p++) begin
      cx[p*CW +: CW] = CW'(xs[p] + cdx);
      cy[p*CW +: CW] = CW'(ys[p] + cdy);
      rx[p*CW +: CW] = CW'(xs[p] + rdx);
      ry[p*CW +: CW] = CW'(ys[p] + rdy);
    end
  endtask

  task automatic drain();
    int t = 0;
    int left;
    while (rq1.size() + rq3.size() + sq1.size() + sq3.size() > 0 && t < 80) begin
      tick();
      t++;
    end
    left = rq1.size() + rq3.size() + sq1.size() + sq3.size();
    checks++;
    if (left != 0) begin
      failures++;
      $error("FAIL drain_timeout: %0d expected events still pending after %0d cycles", left, t);
    end
    repeat (2) tick();
  endtask

  task automatic check_hold();
    repeat (3) tick();
    `CHK("hold_cur1", cp1, last1.cur)
    `CHK("hold_ref1", rp1, last1.rf)
    `CHK("hold_oob1", oob1, last1.oob)
    `CHK("hold_cur3", cp3, last3.cur)
    `CHK("hold_oob3", oob3, last3.oob)
  endtask

  task automatic zchk(input string tag, input logic [111:0] got, input logic [111:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $error("FAIL reset-state %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_zero();
    zchk("z_busy1", 112'(busy1), 112'd0);
    zchk("z_done1", 112'(done1), 112'd0);
    zchk("z_oob1", 112'(oob1), 112'd0);
    zchk("z_en1", 112'(en1), 112'd0);
    zchk("z_sel1", 112'(sel1), 112'd0);
    zchk("z_pix1", {cp1, rp1}, 112'd0);
    zchk("z_busy3", 112'(busy3), 112'd0);
    zchk("z_en3", 112'(en3), 112'd0);
    zchk("z_oob3", 112'(oob3), 112'd0);
    zchk("z_pix3", {cp3, rp3}, 112'd0);
  endtask

  initial begin
    set_pts(0, 0, 2, 0);
    repeat (2) tick();
    check_zero();
    rst_n = 1'b1;
    tick();
    fire(1'b1, 1'b1);
    repeat (3) tick();
    set_pts(40, 40, 40, 40);
    drain();
    check_hold();
    set_pts(0, 0, 2, 0);
    rx[3*CW +: CW] = 7'd96;
    fire(1'b1, 1'b1);
    drain();
    check_hold();
    set_pts(20, 30, 40, 50);
    req1 = 1'b1;
    expect_fetch(1);
    repeat (17) tick();
    expect_fetch(1);
    tick();
    req1 = 1'b0;
    drain();
    set_pts(1, 2, 3, 4);
    fire(1'b0, 1'b1);
    repeat (18) tick();
    set_pts(50, 60, 70, 0);
    cy[6*CW +: CW] = 7'd127;
    fire(1'b0, 1'b1);
    repeat (18) tick();
    set_pts(5, 5, 5, 5);
    fire(1'b0, 1'b1);
    drain();
    check_hold();
    set_pts(0, 0, 2, 0);
    fire(1'b1, 1'b1);
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check_zero();
    rq1.delete(); rq3.delete(); sq1.delete(); sq3.delete();
    repeat (4) tick();
    rst_n = 1'b1;
    tick();
    fire(1'b1, 1'b1);
    drain();
    check_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
